// File: rtl/user_obi_sbr_sched.sv
// OBI request scheduler for the user-domain subordinates: address decode, in-order
// in-flight tracking, and an internal error subordinate for unmapped addresses.
module user_obi_sbr_sched #(
  parameter int unsigned NumSbr       = 1,
  parameter logic [31:0] FirstSbrAddr = 32'h2000_1000,
  parameter logic [31:0] SbrRange     = 32'h0000_1000,
  parameter int unsigned MaxTrans     = 2,
  parameter int unsigned IdWidth      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mgr_req_i,
  output logic                     mgr_gnt_o,
  input  logic [31:0]              mgr_addr_i,
  input  logic                     mgr_we_i,
  input  logic [3:0]               mgr_be_i,
  input  logic [31:0]              mgr_wdata_i,
  input  logic [IdWidth-1:0]       mgr_aid_i,
  output logic                     mgr_rvalid_o,
  output logic [31:0]              mgr_rdata_o,
  output logic                     mgr_err_o,
  output logic [IdWidth-1:0]       mgr_rid_o,
  output logic [NumSbr-1:0]        sbr_req_o,
  input  logic [NumSbr-1:0]        sbr_gnt_i,
  output logic [31:0]              sbr_addr_o,
  output logic                     sbr_we_o,
  output logic [3:0]               sbr_be_o,
  output logic [31:0]              sbr_wdata_o,
  output logic [IdWidth-1:0]       sbr_aid_o,
  input  logic [NumSbr-1:0]        sbr_rvalid_i,
  input  logic [NumSbr*32-1:0]     sbr_rdata_i,
  input  logic [NumSbr-1:0]        sbr_err_i,
  output logic                     proto_err_o
);

  localparam int unsigned TgtW = $clog2(NumSbr + 1);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  // Target index NumSbr is the internal error subordinate.
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSbr);
  localparam logic [31:0] ErrData = 32'hBADC_AB1E;

  logic [TgtW-1:0]    fifo_tgt [MaxTrans];
  logic [IdWidth-1:0] fifo_aid [MaxTrans];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TgtW-1:0]    last_tgt_q;
  logic               err_pending_q, err_pending_d;
  logic               proto_err_q;

  logic [63:0]        win_lo, win_hi;
  logic [TgtW-1:0]    req_tgt, head_tgt, nxt_head_tgt;
  logic [IdWidth-1:0] head_aid;
  logic               allowed, push, pop, proto_set, head_vld, nxt_head_vld;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxTrans - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;
  assign proto_err_o = proto_err_q;

  assign head_vld = (cnt_q != '0);
  assign head_tgt = fifo_tgt[rd_ptr_q];
  assign head_aid = fifo_aid[rd_ptr_q];

  // 64-bit window bounds so the top window cannot wrap past 2^32.
  always_comb begin
    req_tgt = ErrTgt;
    win_lo  = '0;
    win_hi  = '0;
    for (int i = 0; i < NumSbr; i++) begin
      win_lo = 64'(FirstSbrAddr) + 64'(i) * 64'(SbrRange);
      win_hi = win_lo + 64'(SbrRange);
      if (64'(mgr_addr_i) >= win_lo && 64'(mgr_addr_i) < win_hi) req_tgt = TgtW'(i);
    end
  end

  // Only stack requests onto the same target so responses can never reorder.
  assign allowed = (cnt_q < CntW'(MaxTrans)) && (!head_vld || req_tgt == last_tgt_q);

  always_comb begin
    sbr_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (req_tgt == ErrTgt) mgr_gnt_o = mgr_req_i & allowed;
    for (int j = 0; j < NumSbr; j++) begin
      if (req_tgt == TgtW'(j)) begin
        sbr_req_o[j] = mgr_req_i & allowed;
        mgr_gnt_o    = sbr_gnt_i[j] & allowed;
      end
    end
    sbr_req_o = sbr_req_o & {NumSbr{~rst_i}};
    mgr_gnt_o = mgr_gnt_o & ~rst_i;
  end

  always_comb begin
    mgr_rvalid_o = 1'b0;
    mgr_rdata_o  = '0;
    mgr_err_o    = 1'b0;
    mgr_rid_o    = '0;
    proto_set    = 1'b0;
    for (int j = 0; j < NumSbr; j++) begin
      if (sbr_rvalid_i[j]) begin
        if (head_vld && head_tgt == TgtW'(j)) begin
          mgr_rvalid_o = 1'b1;
          mgr_rdata_o  = sbr_rdata_i[32*j +: 32];
          mgr_err_o    = sbr_err_i[j];
        end else begin
          proto_set = 1'b1;
        end
      end
    end
    if (head_vld && head_tgt == ErrTgt && err_pending_q) begin
      mgr_rvalid_o = 1'b1;
      mgr_rdata_o  = ErrData;
      mgr_err_o    = 1'b1;
    end
    if (mgr_rvalid_o) mgr_rid_o = head_aid;
    if (rst_i) begin
      mgr_rvalid_o = 1'b0;
      mgr_rdata_o  = '0;
      mgr_err_o    = 1'b0;
      mgr_rid_o    = '0;
    end
  end

  assign push = mgr_req_i & mgr_gnt_o;
  assign pop  = mgr_rvalid_o;

  // err_pending tracks "an error entry has just become head"; answered one cycle later.
  always_comb begin
    nxt_head_tgt = req_tgt;
    nxt_head_vld = push;
    if (cnt_q > CntW'(1)) begin
      nxt_head_tgt = fifo_tgt[ptr_inc(rd_ptr_q)];
      nxt_head_vld = 1'b1;
    end
    err_pending_d = err_pending_q;
    if (pop)                   err_pending_d = nxt_head_vld && (nxt_head_tgt == ErrTgt);
    else if (!head_vld && push) err_pending_d = (req_tgt == ErrTgt);
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      last_tgt_q    <= ErrTgt;
      err_pending_q <= 1'b0;
      proto_err_q   <= 1'b0;
      for (int k = 0; k < MaxTrans; k++) begin
        fifo_tgt[k] <= ErrTgt;
        fifo_aid[k] <= '0;
      end
    end else begin
      if (push) begin
        fifo_tgt[wr_ptr_q] <= req_tgt;
        fifo_aid[wr_ptr_q] <= mgr_aid_i;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
        last_tgt_q         <= req_tgt;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q         <= cnt_d;
      err_pending_q <= err_pending_d;
      if (proto_set) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_user_obi_sbr_sched.sv
// Directed bench for user_obi_sbr_sched: one subordinate (advanced timer) driven by hand,
// expected values computed by hand per scenario.
module tb_user_obi_sbr_sched;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mgr_req_i = 1'b0, mgr_gnt_o;
  logic [31:0] mgr_addr_i = '0;
  logic        mgr_we_i = 1'b0;
  logic [3:0]  mgr_be_i = 4'hF;
  logic [31:0] mgr_wdata_i = '0;
  logic [0:0]  mgr_aid_i = '0;
  logic        mgr_rvalid_o;
  logic [31:0] mgr_rdata_o;
  logic        mgr_err_o;
  logic [0:0]  mgr_rid_o;
  logic [0:0]  sbr_req_o;
  logic [0:0]  sbr_gnt_i = '0;
  logic [31:0] sbr_addr_o;
  logic        sbr_we_o;
  logic [3:0]  sbr_be_o;
  logic [31:0] sbr_wdata_o;
  logic [0:0]  sbr_aid_o;
  logic [0:0]  sbr_rvalid_i = '0;
  logic [31:0] sbr_rdata_i = '0;
  logic [0:0]  sbr_err_i = '0;
  logic        proto_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  user_obi_sbr_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o), .mgr_rid_o(mgr_rid_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at posedge+1, outputs are checked at posedge+2.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic r, input logic [31:0] a, input logic id, input logic g);
    mgr_req_i  = r;
    mgr_addr_i = a;
    mgr_aid_i  = id;
    sbr_gnt_i  = g;
  endtask

  task automatic drive_rsp(input logic v, input logic [31:0] d, input logic e);
    sbr_rvalid_i = v;
    sbr_rdata_i  = d;
    sbr_err_i    = e;
  endtask

  task automatic test_reset();
    drive_req(1'b1, 32'h2000_1000, 1'b0, 1'b1);
    drive_rsp(1'b1, 32'h1, 1'b0);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %0h exp 0", mgr_gnt_o); end
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %0h exp 0", mgr_rvalid_o); end
    n_cmp++; if (sbr_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_sbr_req: got %0h exp 0", sbr_req_o); end
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_proto: got %0h exp 0", proto_err_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    drive_rsp(1'b0, 32'h0, 1'b0);
    rst_i = 1'b0;
    #1;
    n_cmp++; if (mgr_rdata_o !== 32'h0) begin n_bad++; $display("FAIL idle_rdata: got %h exp 0", mgr_rdata_o); end
    next_cycle();
  endtask

  task automatic test_timer_read();
    drive_req(1'b1, 32'h2000_1000, 1'b1, 1'b1);
    mgr_wdata_i = 32'hCAFE_0001;
    #1;
    n_cmp++; if (sbr_req_o !== 1'b1) begin n_bad++; $display("FAIL rd_sbr_req: got %0h exp 1", sbr_req_o); end
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %0h exp 1", mgr_gnt_o); end
    n_cmp++; if (sbr_addr_o !== 32'h2000_1000 || sbr_aid_o !== 1'b1 || sbr_wdata_o !== 32'hCAFE_0001)
      begin n_bad++; $display("FAIL rd_bcast: got %h/%0h/%h exp 20001000/1/cafe0001", sbr_addr_o, sbr_aid_o, sbr_wdata_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rd_wait_rvalid: got %0h exp 0", mgr_rvalid_o); end
    next_cycle();
    drive_rsp(1'b1, 32'h0000_1234, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %0h exp 1", mgr_rvalid_o); end
    n_cmp++; if (mgr_rdata_o !== 32'h1234) begin n_bad++; $display("FAIL rd_rdata: got %h exp 00001234", mgr_rdata_o); end
    n_cmp++; if (mgr_err_o !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %0h exp 0", mgr_err_o); end
    n_cmp++; if (mgr_rid_o !== 1'b1) begin n_bad++; $display("FAIL rd_rid: got %0h exp 1", mgr_rid_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0 || mgr_rid_o !== 1'b0) begin n_bad++; $display("FAIL rd_after: got rvalid %0h rid %0h exp 0/0", mgr_rvalid_o, mgr_rid_o); end
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rd_proto: got %0h exp 0", proto_err_o); end
    next_cycle();
  endtask

  task automatic test_err_read();
    drive_req(1'b1, 32'h2000_0000, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL err_gnt: got %0h exp 1", mgr_gnt_o); end
    n_cmp++; if (sbr_req_o !== 1'b0) begin n_bad++; $display("FAIL err_sbr_req: got %0h exp 0", sbr_req_o); end
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL err_early_rvalid: got %0h exp 0", mgr_rvalid_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_err_o !== 1'b1) begin n_bad++; $display("FAIL err_rsp: got rvalid %0h err %0h exp 1/1", mgr_rvalid_o, mgr_err_o); end
    n_cmp++; if (mgr_rdata_o !== 32'hBADC_AB1E) begin n_bad++; $display("FAIL err_rdata: got %h exp badcab1e", mgr_rdata_o); end
    n_cmp++; if (mgr_rid_o !== 1'b0) begin n_bad++; $display("FAIL err_rid: got %0h exp 0", mgr_rid_o); end
    next_cycle();
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0 || mgr_err_o !== 1'b0) begin n_bad++; $display("FAIL err_after: got rvalid %0h err %0h exp 0/0", mgr_rvalid_o, mgr_err_o); end
    next_cycle();
  endtask

  task automatic test_decode_bounds();
    // Last word of the timer window, subordinate not granting: no push.
    drive_req(1'b1, 32'h2000_1FFC, 1'b0, 1'b0);
    #1;
    n_cmp++; if (sbr_req_o !== 1'b1 || mgr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL dec_top: got req %0h gnt %0h exp 1/0", sbr_req_o, mgr_gnt_o); end
    next_cycle();
    // First address past the window goes to the error subordinate.
    drive_req(1'b1, 32'h2000_2000, 1'b1, 1'b0);
    #1;
    n_cmp++; if (sbr_req_o !== 1'b0 || mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL dec_past: got req %0h gnt %0h exp 0/1", sbr_req_o, mgr_gnt_o); end
    next_cycle();
    // Second error request back-to-back: granted while the first is answered.
    drive_req(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b1 || mgr_gnt_o !== 1'b1)
      begin n_bad++; $display("FAIL dec_err1: got rvalid %0h rid %0h gnt %0h exp 1/1/1", mgr_rvalid_o, mgr_rid_o, mgr_gnt_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b0 || mgr_err_o !== 1'b1)
      begin n_bad++; $display("FAIL dec_err2: got rvalid %0h rid %0h err %0h exp 1/0/1", mgr_rvalid_o, mgr_rid_o, mgr_err_o); end
    next_cycle();
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL dec_done: got %0h exp 0", mgr_rvalid_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 32'h2000_1000, 1'b0, 1'b1);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt1: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b1, 32'h2000_1004, 1'b1, 1'b1);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt2: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b1, 32'h2000_1008, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (mgr_gnt_o !== 1'b0 || sbr_req_o !== 1'b0)
        begin n_bad++; $display("FAIL b2b_full%0d: got gnt %0h req %0h exp 0/0", c, mgr_gnt_o, sbr_req_o); end
      next_cycle();
    end
    drive_rsp(1'b1, 32'h0000_AAAA, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b0 || mgr_rdata_o !== 32'hAAAA)
      begin n_bad++; $display("FAIL b2b_rsp1: got rvalid %0h rid %0h rdata %h exp 1/0/0000aaaa", mgr_rvalid_o, mgr_rid_o, mgr_rdata_o); end
    n_cmp++; if (mgr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL b2b_popgnt: got %0h exp 0", mgr_gnt_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt3: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    drive_rsp(1'b1, 32'h0000_BBBB, 1'b1);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b1 || mgr_rdata_o !== 32'hBBBB || mgr_err_o !== 1'b1)
      begin n_bad++; $display("FAIL b2b_rsp2: got rvalid %0h rid %0h rdata %h err %0h exp 1/1/0000bbbb/1", mgr_rvalid_o, mgr_rid_o, mgr_rdata_o, mgr_err_o); end
    next_cycle();
    drive_rsp(1'b1, 32'h0000_CCCC, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b0 || mgr_rdata_o !== 32'hCCCC)
      begin n_bad++; $display("FAIL b2b_rsp3: got rvalid %0h rid %0h rdata %h exp 1/0/0000cccc", mgr_rvalid_o, mgr_rid_o, mgr_rdata_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL b2b_proto: got %0h exp 0", proto_err_o); end
    next_cycle();
  endtask

  task automatic test_ordering();
    drive_req(1'b1, 32'h2000_1010, 1'b1, 1'b1);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL ord_gnt_tmr: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b1, 32'h3000_0000, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (mgr_gnt_o !== 1'b0 || mgr_rvalid_o !== 1'b0)
        begin n_bad++; $display("FAIL ord_hold%0d: got gnt %0h rvalid %0h exp 0/0", c, mgr_gnt_o, mgr_rvalid_o); end
      next_cycle();
    end
    drive_rsp(1'b1, 32'h0000_0055, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rid_o !== 1'b1 || mgr_rdata_o !== 32'h55 || mgr_err_o !== 1'b0)
      begin n_bad++; $display("FAIL ord_tmr_rsp: got rvalid %0h rid %0h rdata %h err %0h exp 1/1/00000055/0", mgr_rvalid_o, mgr_rid_o, mgr_rdata_o, mgr_err_o); end
    n_cmp++; if (mgr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL ord_gnt_pop: got %0h exp 0", mgr_gnt_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1 || mgr_rvalid_o !== 1'b0)
      begin n_bad++; $display("FAIL ord_err_gnt: got gnt %0h rvalid %0h exp 1/0", mgr_gnt_o, mgr_rvalid_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_err_o !== 1'b1 || mgr_rdata_o !== 32'hBADC_AB1E || mgr_rid_o !== 1'b0)
      begin n_bad++; $display("FAIL ord_err_rsp: got rvalid %0h err %0h rdata %h rid %0h exp 1/1/badcab1e/0", mgr_rvalid_o, mgr_err_o, mgr_rdata_o, mgr_rid_o); end
    next_cycle();
  endtask

  task automatic test_proto_err();
    drive_rsp(1'b1, 32'h0000_0099, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL pe_rvalid: got %0h exp 0", mgr_rvalid_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (proto_err_o !== 1'b1) begin n_bad++; $display("FAIL pe_sticky%0d: got %0h exp 1", c, proto_err_o); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 32'h2000_1000, 1'b0, 1'b1);
    next_cycle();
    drive_req(1'b1, 32'h2000_1004, 1'b1, 1'b1);
    next_cycle();
    rst_i = 1'b1;
    drive_rsp(1'b1, 32'h0000_0011, 1'b0);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b0 || mgr_rvalid_o !== 1'b0 || sbr_req_o !== 1'b0)
      begin n_bad++; $display("FAIL rm_in_rst: got gnt %0h rvalid %0h req %0h exp 0/0/0", mgr_gnt_o, mgr_rvalid_o, sbr_req_o); end
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_proto_clr: got %0h exp 0", proto_err_o); end
    next_cycle();
    rst_i = 1'b0;
    drive_rsp(1'b0, 32'h0, 1'b0);
    drive_req(1'b1, 32'h2000_1000, 1'b1, 1'b1);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt1: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b1, 32'h2000_1008, 1'b0, 1'b1);
    #1;
    n_cmp++; if (mgr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt2: got %0h exp 1", mgr_gnt_o); end
    next_cycle();
    drive_req(1'b0, 32'h0, 1'b0, 1'b0);
    drive_rsp(1'b1, 32'h0000_0077, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rdata_o !== 32'h77 || mgr_rid_o !== 1'b1)
      begin n_bad++; $display("FAIL rm_rsp1: got rvalid %0h rdata %h rid %0h exp 1/00000077/1", mgr_rvalid_o, mgr_rdata_o, mgr_rid_o); end
    next_cycle();
    drive_rsp(1'b1, 32'h0000_0088, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b1 || mgr_rdata_o !== 32'h88 || mgr_rid_o !== 1'b0)
      begin n_bad++; $display("FAIL rm_rsp2: got rvalid %0h rdata %h rid %0h exp 1/00000088/0", mgr_rvalid_o, mgr_rdata_o, mgr_rid_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_proto_ok: got %0h exp 0", proto_err_o); end
    next_cycle();
    // A late response with nothing outstanding is flagged.
    drive_rsp(1'b1, 32'h0000_0066, 1'b0);
    #1;
    n_cmp++; if (mgr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rm_late_rvalid: got %0h exp 0", mgr_rvalid_o); end
    next_cycle();
    drive_rsp(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (proto_err_o !== 1'b1) begin n_bad++; $display("FAIL rm_late_proto: got %0h exp 1", proto_err_o); end
    next_cycle();
  endtask

  initial begin
    #1;
    test_reset();
    test_timer_read();
    test_err_read();
    test_decode_bounds();
    test_back_to_back();
    test_ordering();
    test_proto_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
